// File: rtl/cve2_rvfi_trace_buffer.sv
// Circular buffer of RVFI retirement records, drained over a valid/ready stream.
// Also counts dropped records, marks stream gaps and checks retirement-order continuity.
module cve2_rvfi_trace_buffer #(
  parameter int unsigned Depth      = 16,
  parameter bit          StopOnFull = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic                       rvfi_valid_i,
  input  logic [63:0]                rvfi_order_i,
  input  logic [31:0]                rvfi_pc_rdata_i,
  input  logic [31:0]                rvfi_insn_i,
  input  logic [4:0]                 rvfi_rd_addr_i,
  input  logic [31:0]                rvfi_rd_wdata_i,
  input  logic                       rvfi_trap_i,
  input  logic                       rvfi_intr_i,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [31:0]                trace_pc_o,
  output logic [31:0]                trace_insn_o,
  output logic [31:0]                trace_rd_wdata_o,
  output logic [4:0]                 trace_rd_addr_o,
  output logic [2:0]                 trace_flags_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic [15:0]                drop_cnt_o,
  output logic                       stopped_o,
  output logic                       order_err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned RecW = 104;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);

  logic [RecW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] count_q, count_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            gap_q, gap_d;
  logic            stopped_q, stopped_d;
  logic            order_err_q, order_err_d;
  logic            order_seen_q, order_seen_d;
  logic [63:0]     last_order_q, last_order_d;

  logic            not_empty, cap, pop, space, push, drop;
  logic [RecW-1:0] wr_rec, head;

  assign not_empty = (count_q != '0);
  assign pop       = not_empty & trace_ready_i;
  assign cap       = rvfi_valid_i & enable_i & ~stopped_q;
  // A pop in the same cycle frees the slot a full-buffer write needs.
  assign space     = (count_q != LvlFull) | pop;
  assign push      = cap & space & ~clear_i;
  assign drop      = cap & ~space;

  assign wr_rec = {gap_q, rvfi_intr_i, rvfi_trap_i, rvfi_rd_addr_i, rvfi_rd_wdata_i,
                   rvfi_insn_i, rvfi_pc_rdata_i};

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_cnt_d   = drop_cnt_q;
    gap_d        = gap_q;
    stopped_d    = stopped_q;
    order_err_d  = order_err_q;
    order_seen_d = order_seen_q;
    last_order_d = last_order_q;

    if (clear_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      drop_cnt_d   = '0;
      gap_d        = 1'b0;
      stopped_d    = 1'b0;
      order_err_d  = 1'b0;
      order_seen_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        gap_d    = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + LvlW'(1);
        2'b01:   count_d = count_q - LvlW'(1);
        default: ;
      endcase

      if (drop) begin
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
        gap_d = 1'b1;
        if (StopOnFull) begin
          stopped_d = 1'b1;
        end
      end

      // Continuity is tracked on the raw retirement stream, independent of capture.
      if (rvfi_valid_i) begin
        if (order_seen_q && (rvfi_order_i != last_order_q + 64'd1)) begin
          order_err_d = 1'b1;
        end
        last_order_d = rvfi_order_i;
        order_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      gap_q        <= 1'b0;
      stopped_q    <= 1'b0;
      order_err_q  <= 1'b0;
      order_seen_q <= 1'b0;
      last_order_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      gap_q        <= gap_d;
      stopped_q    <= stopped_d;
      order_err_q  <= order_err_d;
      order_seen_q <= order_seen_d;
      last_order_q <= last_order_d;
    end
  end

  // Record storage needs no reset: the head read is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= wr_rec;
    end
  end

  assign head = not_empty ? mem_q[rd_ptr_q] : '0;

  assign trace_valid_o    = not_empty;
  assign trace_pc_o       = head[31:0];
  assign trace_insn_o     = head[63:32];
  assign trace_rd_wdata_o = head[95:64];
  assign trace_rd_addr_o  = head[100:96];
  assign trace_flags_o    = head[103:101];
  assign level_o          = count_q;
  assign drop_cnt_o       = drop_cnt_q;
  assign stopped_o        = stopped_q;
  assign order_err_o      = order_err_q;

endmodule

// File: tb/tb_cve2_rvfi_trace_buffer.sv
// Bench for cve2_rvfi_trace_buffer: two instances (free-running and stop-on-full) share one
// stimulus stream and are compared every cycle against a queue-based reference model.
module tb_cve2_rvfi_trace_buffer;

  localparam int Depth = 16;

  typedef struct {
    bit          gap, intr, trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, insn, pc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, clear = 1'b0, valid = 1'b0, ready = 1'b0;
  logic [63:0] order = '0;
  logic [31:0] pc = '0, insn = '0, wdata = '0;
  logic [4:0]  rd_addr = '0;
  logic        trap = 1'b0, intr = 1'b0;

  logic        t_valid [2];
  logic [31:0] t_pc [2], t_insn [2], t_wdata [2];
  logic [4:0]  t_rd [2];
  logic [2:0]  t_flags [2];
  logic [4:0]  t_level [2];
  logic [15:0] t_drop [2];
  logic        t_stop [2], t_err [2];

  rec_t        m_q [2][$];
  int          m_drop [2];
  bit          m_gap [2], m_stop [2], m_err [2], m_seen [2];
  logic [63:0] m_last [2];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] next_order = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cve2_rvfi_trace_buffer #(
      .Depth      (Depth),
      .StopOnFull (g == 1)
    ) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .enable_i         (enable),
      .clear_i          (clear),
      .rvfi_valid_i     (valid),
      .rvfi_order_i     (order),
      .rvfi_pc_rdata_i  (pc),
      .rvfi_insn_i      (insn),
      .rvfi_rd_addr_i   (rd_addr),
      .rvfi_rd_wdata_i  (wdata),
      .rvfi_trap_i      (trap),
      .rvfi_intr_i      (intr),
      .trace_valid_o    (t_valid[g]),
      .trace_ready_i    (ready),
      .trace_pc_o       (t_pc[g]),
      .trace_insn_o     (t_insn[g]),
      .trace_rd_wdata_o (t_wdata[g]),
      .trace_rd_addr_o  (t_rd[g]),
      .trace_flags_o    (t_flags[g]),
      .level_o          (t_level[g]),
      .drop_cnt_o       (t_drop[g]),
      .stopped_o        (t_stop[g]),
      .order_err_o      (t_err[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input int i);
    m_q[i].delete();
    m_drop[i] = 0;
    m_gap[i]  = 1'b0;
    m_stop[i] = 1'b0;
    m_err[i]  = 1'b0;
    m_seen[i] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(input int i);
    rec_t r;
    bit   pop_e, cap_e, space_e;
    if (rst || clear) begin
      model_clear(i);
      return;
    end
    pop_e   = (m_q[i].size() > 0) && ready;
    cap_e   = valid && enable && !m_stop[i];
    space_e = (m_q[i].size() < Depth) || pop_e;
    if (pop_e) void'(m_q[i].pop_front());
    if (cap_e && space_e) begin
      r.gap = m_gap[i]; r.intr = intr; r.trap = trap; r.rd_addr = rd_addr;
      r.rd_wdata = wdata; r.insn = insn; r.pc = pc;
      m_q[i].push_back(r);
      m_gap[i] = 1'b0;
    end else if (cap_e) begin
      if (m_drop[i] < 65535) m_drop[i]++;
      m_gap[i] = 1'b1;
      if (i == 1) m_stop[i] = 1'b1;
    end
    if (valid) begin
      if (m_seen[i] && order != m_last[i] + 64'd1) m_err[i] = 1'b1;
      m_last[i] = order;
      m_seen[i] = 1'b1;
    end
  endtask

  task automatic check_all(input int i);
    rec_t h;
    bit   has;
    has = m_q[i].size() > 0;
    if (has) h = m_q[i][0];
    else begin
      h.gap = 0; h.intr = 0; h.trap = 0; h.rd_addr = '0; h.rd_wdata = '0; h.insn = '0; h.pc = '0;
    end
    check($sformatf("d%0d_valid", i), 64'(t_valid[i]), 64'(has));
    check($sformatf("d%0d_pc", i), 64'(t_pc[i]), 64'(h.pc));
    check($sformatf("d%0d_insn", i), 64'(t_insn[i]), 64'(h.insn));
    check($sformatf("d%0d_wdata", i), 64'(t_wdata[i]), 64'(h.rd_wdata));
    check($sformatf("d%0d_rd_flags", i), 64'({t_flags[i], t_rd[i]}),
          64'({h.gap, h.intr, h.trap, h.rd_addr}));
    check($sformatf("d%0d_level", i), 64'(t_level[i]), 64'(m_q[i].size()));
    check($sformatf("d%0d_drop", i), 64'(t_drop[i]), 64'(m_drop[i]));
    check($sformatf("d%0d_stopped", i), 64'(t_stop[i]), 64'(m_stop[i]));
    check($sformatf("d%0d_order_err", i), 64'(t_err[i]), 64'(m_err[i]));
  endtask

  task automatic tick();
    check_all(0);
    check_all(1);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input bit v, input logic [63:0] ord);
    valid   = v;
    order   = ord;
    pc      = $urandom;
    insn    = $urandom;
    wdata   = $urandom;
    rd_addr = 5'($urandom);
    trap    = 1'($urandom);
    intr    = 1'($urandom);
  endtask

  task automatic push_rec();
    set_rec(1'b1, next_order);
    next_order++;
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear(0);
    model_clear(1);
    enable = 1'b1;
    ready  = 1'b1;

    // Short in-order stream drained as it arrives.
    for (int k = 0; k < 5; k++) begin
      set_rec(1'b1, 64'(k));
      pc = 32'h80 + 32'(4 * k);
      tick();
      check("stream_level_le1", 64'(t_level[0] <= 5'd1), 64'd1);
    end
    valid = 1'b0;
    next_order = 64'd5;
    repeat (3) tick();

    // Overfill with consumer stalled.
    ready = 1'b0;
    repeat (20) push_rec();
    tick();
    check("full_level", 64'(t_level[0]), 64'd16);
    check("full_drop", 64'(t_drop[0]), 64'd4);
    check("stop_drop", 64'(t_drop[1]), 64'd1);
    check("stop_set", 64'(t_stop[1]), 64'd1);
    ready = 1'b1;
    push_rec();
    repeat (20) tick();
    repeat (3) push_rec();
    tick();
    check("stop_ignores", 64'(t_level[1]), 64'd0);
    pulse_clear();
    check("stop_cleared", 64'(t_stop[1]), 64'd0);
    ready = 1'b0;
    push_rec();
    check("stop_resumed", 64'(t_level[1]), 64'd1);

    // Full buffer with a push and a pop every cycle across pointer wrap.
    pulse_clear();
    repeat (16) push_rec();
    ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_rec(1'b1, next_order);
      next_order++;
      tick();
    end
    valid = 1'b0;
    check("wrap_level", 64'(t_level[0]), 64'd16);
    check("wrap_drop", 64'(t_drop[0]), 64'd0);
    repeat (18) tick();

    // Order discontinuity, then clear with a record present.
    pulse_clear();
    set_rec(1'b1, 64'd7);  tick();
    set_rec(1'b1, 64'd8);  tick();
    set_rec(1'b1, 64'd10); tick();
    valid = 1'b0;
    check("order_err_rise", 64'(t_err[0]), 64'd1);
    repeat (2) tick();
    set_rec(1'b1, 64'd11);
    pulse_clear();
    check("order_err_clr", 64'(t_err[0]), 64'd0);
    next_order = 64'd100;

    // Clear racing a push and a pop at level 9.
    ready = 1'b0;
    repeat (9) push_rec();
    ready = 1'b1;
    set_rec(1'b1, next_order);
    pulse_clear();
    valid = 1'b0;
    check("clr_level", 64'(t_level[0]), 64'd0);
    check("clr_valid", 64'(t_valid[0]), 64'd0);
    check("clr_drop", 64'(t_drop[0]), 64'd0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      set_rec($urandom_range(0, 99) < 70, next_order);
      if ($urandom_range(0, 99) < 3) order = {$urandom, $urandom};
      if (valid) next_order = order + 64'd1;
      ready  = $urandom_range(0, 99) < 45;
      enable = $urandom_range(0, 99) < 92;
      clear  = $urandom_range(0, 99) < 2;
      tick();
    end
    clear = 1'b0;
    valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
